// File: rtl/alu_sequencer_if.sv
// Instruction handshake, ALU bus and debug port of the ALU sequencer.
interface alu_sequencer_if #(
  parameter int unsigned DATA_W = 16
);
  // Instruction handshake
  logic              inst_valid;
  logic [15:0]       inst;
  logic              inst_ready;
  logic              done;
  logic              err;
  // ALU bus
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [4:0]        alu_op;
  logic              alu_cin;
  logic [DATA_W-1:0] alu_y;
  logic [4:0]        alu_flags;
  // Status and debug
  logic [4:0]        psr;
  logic [3:0]        dbg_addr;
  logic [DATA_W-1:0] dbg_data;

  // Sequencer side
  modport slave (
    input  inst_valid, inst, alu_y, alu_flags, dbg_addr,
    output inst_ready, done, err, alu_a, alu_b, alu_op, alu_cin, psr, dbg_data
  );

  // Instruction source / ALU / debugger side
  modport master (
    output inst_valid, inst, alu_y, alu_flags, dbg_addr,
    input  inst_ready, done, err, alu_a, alu_b, alu_op, alu_cin, psr, dbg_data
  );
endinterface

// File: rtl/alu_sequencer.sv
// Four-state instruction sequencer wrapped around an external ALU. Holds a
// 16x16 register file and a 5-bit status register {Z, C, F, N, L}.
module alu_sequencer #(
  parameter int unsigned DATA_W = 16
) (
  input logic            clk,
  input logic            reset_n,
  alu_sequencer_if.slave bus
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRead = 2'd1;
  localparam logic [1:0] StExec = 2'd2;
  localparam logic [1:0] StWb   = 2'd3;

  // Status bits that arithmetic and compare instructions may change
  localparam logic [4:0] MaskArith = 5'b01100;  // C, F
  localparam logic [4:0] MaskCmp   = 5'b10011;  // Z, N, L

  logic [1:0]        state_q, state_d;
  logic [15:0]       inst_q, inst_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  logic [4:0]        alu_op_q, alu_op_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic [4:0]        flags_q, flags_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [4:0]        psr_q, psr_d;
  logic [DATA_W-1:0] rf_q [16];
  logic [DATA_W-1:0] rf_d [16];

  // Decoded fields of the latched instruction
  logic [3:0]        op, rd, rs, ext, code;
  logic [7:0]        imm;
  logic              is_rtype, is_movi, is_lui;
  logic              code_ok, zext, wr_en, undef;
  logic [DATA_W-1:0] imm_ext;
  logic [4:0]        psr_mask;

  // Instruction decode: code selection, immediate extension, writeback and psr masks
  always_comb begin
    op       = inst_q[15:12];
    rd       = inst_q[11:8];
    ext      = inst_q[7:4];
    rs       = inst_q[3:0];
    imm      = inst_q[7:0];
    is_rtype = (op == 4'b0000);
    is_movi  = (op == 4'b1101);
    is_lui   = (op == 4'b1111);
    code     = is_rtype ? ext : op;
    code_ok  = 1'b0;
    zext     = 1'b0;
    psr_mask = 5'b00000;
    case (code)
      4'b0001, 4'b0010, 4'b0011: begin
        code_ok = 1'b1;
        zext    = 1'b1;
      end
      4'b0101, 4'b0110, 4'b0111, 4'b1001: begin
        code_ok  = 1'b1;
        psr_mask = MaskArith;
      end
      4'b1011: begin
        code_ok  = 1'b1;
        psr_mask = MaskCmp;
      end
      4'b1110: code_ok = 1'b1;
      default: code_ok = 1'b0;
    endcase
    // MOVI/LUI codes are not ALU codes, so code_ok is already clear for them
    undef   = !(code_ok || is_movi || is_lui);
    wr_en   = is_movi || is_lui || (code_ok && (code != 4'b1011));
    imm_ext = zext ? {8'h00, imm} : {{8{imm[7]}}, imm};
  end

  // Next-state logic for the sequencer FSM, datapath registers and register file
  always_comb begin
    state_d  = state_q;
    inst_d   = inst_q;
    alu_a_d  = alu_a_q;
    alu_b_d  = alu_b_q;
    alu_op_d = alu_op_q;
    res_d    = res_q;
    flags_d  = flags_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    psr_d    = psr_q;
    rf_d     = rf_q;
    case (state_q)
      StIdle: begin
        if (bus.inst_valid) begin
          inst_d  = bus.inst;
          state_d = StRead;
        end
      end
      StRead: begin
        alu_a_d  = rf_q[rd];
        alu_b_d  = is_rtype ? rf_q[rs] : imm_ext;
        alu_op_d = {1'b0, code};
        state_d  = StExec;
      end
      StExec: begin
        if (is_movi) begin
          res_d = {8'h00, imm};
        end else if (is_lui) begin
          res_d = {imm, 8'h00};
        end else begin
          res_d = bus.alu_y;
        end
        flags_d = bus.alu_flags;
        // done/err are registered so they are high for exactly the WB cycle
        done_d  = 1'b1;
        err_d   = undef;
        state_d = StWb;
      end
      StWb: begin
        if (wr_en) begin
          rf_d[rd] = res_q;
        end
        psr_d   = (psr_q & ~psr_mask) | (flags_q & psr_mask);
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      inst_q   <= '0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      alu_op_q <= '0;
      res_q    <= '0;
      flags_q  <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      psr_q    <= '0;
      for (int i = 0; i < 16; i++) begin
        rf_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      inst_q   <= inst_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
      alu_op_q <= alu_op_d;
      res_q    <= res_d;
      flags_q  <= flags_d;
      done_q   <= done_d;
      err_q    <= err_d;
      psr_q    <= psr_d;
      rf_q     <= rf_d;
    end
  end

  // Output drive; dbg_data is a combinational register-file read
  always_comb begin
    bus.inst_ready = (state_q == StIdle);
    bus.done       = done_q;
    bus.err        = err_q;
    bus.alu_a      = alu_a_q;
    bus.alu_b      = alu_b_q;
    bus.alu_op     = alu_op_q;
    bus.alu_cin    = psr_q[3];
    bus.psr        = psr_q;
    bus.dbg_data   = rf_q[bus.dbg_addr];
  end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter: DATA_W, 16, datapath and register width; the only supported value is 16.
REQ-002 clk  input  1  rising-edge system clock.
REQ-003 reset_n  input  1  synchronous, active-low reset.
REQ-004 inst_valid  input  1  instruction word on inst is valid.
REQ-005 inst  input  16  instruction: [15:12] op, [11:8] Rdest, [7:4] ext or imm[7:4], [3:0] Rsrc or imm[3:0].
REQ-006 inst_ready  output  1  sequencer can accept an instruction.
REQ-007 done  output  1  one-cycle pulse when an instruction retires.
REQ-008 err  output  1  one-cycle pulse, coincident with done, when the instruction is undefined.
REQ-009 alu_a  output  16  ALU operand A (Rdest value).
REQ-010 alu_b  output  16  ALU operand B (Rsrc value or extended immediate).
REQ-011 alu_op  output  5  ALU opcode, equal to {1'b0, code}.
REQ-012 alu_cin  output  1  carry-in to the ALU, equal to psr[3].
REQ-013 alu_y  input  16  ALU result.
REQ-014 alu_flags  input  5  ALU flags {Z, C, F, N, L}.
REQ-015 psr  output  5  latched processor status {Z, C, F, N, L}.
REQ-016 dbg_addr  input  4  debug register-file read address.
REQ-017 dbg_data  output  16  combinational read of register dbg_addr.

Function
REQ-018 The block SHALL contain a 16x16 register file (R0 to R15, R0 general purpose) and the 5-bit psr register.
REQ-019 Operation codes: AND 0001, OR 0010, XOR 0011, ADD 0101, ADDU 0110, ADDC 0111, SUB 1001, CMP 1011, MUL 1110.
REQ-020 R-type: op=0000, code=inst[7:4], alu_b=R[Rsrc].
REQ-021 I-type: op=code, imm=inst[7:0]; imm is zero-extended for AND, OR and XOR, and sign-extended for all other codes.
REQ-022 op=1101 MOVI: Rdest := {8'h00, imm}; the ALU is not used and psr is unchanged.
REQ-023 op=1111 LUI: Rdest := {imm, 8'h00}; the ALU is not used and psr is unchanged.
REQ-024 Undefined instructions: op in {0100, 1000, 1010, 1100}, or an R-type ext not listed in REQ-019. These SHALL write no register, leave psr unchanged, and assert err with done.
REQ-025 FSM states: IDLE, READ, EXEC, WB.
REQ-026 IDLE: inst_ready=1; when inst_valid is high, latch inst and go to READ.
REQ-027 READ: register R[Rdest], R[Rsrc] and the extended immediate into operand registers; go to EXEC.
REQ-028 EXEC: drive alu_a, alu_b and alu_op from registers; at the clock edge, capture alu_y and alu_flags; go to WB.
REQ-029 WB: write the result, update psr, pulse done (and err if applicable); return to IDLE.
REQ-030 Latency: accept at edge 0, done high in cycle 3. Throughput is one instruction per 4 cycles.
REQ-031 inst_ready SHALL be 0 in READ, EXEC and WB; inst and inst_valid are ignored in those states.
REQ-032 Writeback targets Rdest for all defined codes except CMP, which writes no register.
REQ-033 psr update mask: ADD, ADDU, ADDC and SUB update C and F; CMP updates Z, N and L; AND, OR, XOR, MUL, MOVI and LUI leave psr unchanged; unmasked bits hold.
REQ-034 alu_a, alu_b and alu_op SHALL hold their last values outside EXEC.
REQ-035 Wrap-around: results are truncated to 16 bits with no saturation.
REQ-036 alu_cin SHALL reflect psr[3] as it stands before the current instruction's writeback.
REQ-037 dbg_data is combinational from the register file. A write in WB SHALL be visible on dbg_data in the cycle after WB.

Reset
REQ-038 When reset_n=0 at a clock edge: state := IDLE, all registers := 0, psr := 5'b0, done := 0, err := 0, alu_a := 0, alu_b := 0, alu_op := 0.
REQ-039 A reset in READ, EXEC or WB SHALL abort the instruction, with no writeback, no psr update and no done pulse.
REQ-040 inst_ready SHALL be 1 in the first cycle after reset_n returns to 1.

Verification (real ALU attached)
REQ-041 LUI R1,0x7F; ORI R1,0xFF; ADDI R1,0x01 -> dbg R1=0x8000; psr F=1, C=0; each instruction gives done exactly 3 cycles after acceptance.
REQ-042 LUI R2,0xFF; ORI R2,0xFF; MOVI R3,0x01; ADDU R2,R3 -> R2=0x0000, psr C=1, F=0.
REQ-043 Following REQ-042 (C=1): MOVI R4,0x02; MOVI R5,0x03; ADDC R4,R5 -> R4=0x0006, and alu_cin=1 during EXEC.
REQ-044 CMP R4,R4 -> psr Z=1, R4 unchanged; C and F unchanged from the prior instruction. Then instruction 0x4123 -> done and err pulse together; all registers and psr unchanged.
REQ-045 inst_valid held high continuously -> an instruction is accepted only every 4th cycle, and inst_ready=0 in the three cycles between.
REQ-046 reset_n=0 during EXEC of ADDI R1,0x05 -> no done pulse, R1=0, psr=0, inst_ready=1 in the cycle after reset_n rises.
